// File: rtl/completion_queue.sv
// completion_queue: FIFO of completed addresses feeding an SPI serializer that loads on its own
// negedge. Build option: define COMPLETION_QUEUE_RETRY_EN to re-offer heads aborted by ser_err.
module completion_queue #(
  parameter int ADDRW = 23,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  input  logic [ADDRW-1:0] push_addr,
  output logic             push_ready,
  input  logic             ser_ready,
  input  logic             ser_err,
  output logic             ser_valid,
  output logic [ADDRW-1:0] ser_addr,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic [7:0]       abort_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OFFER    = 2'd1,
    INFLIGHT = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             ser_ready_q;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr_next;
  logic [PW-1:0]    wr_ptr_next;
  logic [CW-1:0]    count_next;
  logic [CW-1:0]    remain;
  logic [ADDRW-1:0] mem [DEPTH];

  logic             accept;
  logic             done;
  logic             do_push;
  logic             do_pop;

  logic             ser_valid_next;
  logic [ADDRW-1:0] ser_addr_next;
  logic             push_ready_next;
  logic             overflow_next;
  logic [7:0]       abort_cnt_next;

  // The serializer's load and completion are only visible as edges on its ready_out.
  always_comb begin
    accept  = (state == OFFER) && ser_ready_q && !ser_ready;
    done    = (state == INFLIGHT) && !ser_ready_q && ser_ready;
    do_push = push_valid && push_ready;
`ifdef COMPLETION_QUEUE_RETRY_EN
    do_pop  = done && !ser_err;
`else
    do_pop  = done;
`endif
  end

  always_comb begin
    if (do_pop) begin
      rd_ptr_next = rd_ptr + PW'(1);
      remain      = count - CW'(1);
    end else begin
      rd_ptr_next = rd_ptr;
      remain      = count;
    end

    if (do_push) begin
      wr_ptr_next = wr_ptr + PW'(1);
    end else begin
      wr_ptr_next = wr_ptr;
    end

    case ({do_push, do_pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase

    push_ready_next = (count_next != FULL_COUNT);
    overflow_next   = push_valid && !push_ready;

    if (done && ser_err && (abort_cnt != 8'hFF)) begin
      abort_cnt_next = abort_cnt + 8'd1;
    end else begin
      abort_cnt_next = abort_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ser_ready_q <= 1'b1;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else begin
      state       <= state_next;
      ser_ready_q <= ser_ready;
      rd_ptr      <= rd_ptr_next;
      wr_ptr      <= wr_ptr_next;
      count       <= count_next;
    end
  end

  // Storage carries no reset; only entries below count are ever presented.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_addr;
    end
  end

  // A same-cycle push is not counted in "remain", so a completion that empties the
  // queue goes via IDLE and reaches OFFER a cycle later with the new entry settled.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (count != '0) begin
          state_next = OFFER;
        end else begin
          state_next = IDLE;
        end
      end
      OFFER: begin
        if (accept) begin
          state_next = INFLIGHT;
        end else begin
          state_next = OFFER;
        end
      end
      INFLIGHT: begin
        if (done) begin
          if (remain != '0) begin
            state_next = OFFER;
          end else begin
            state_next = IDLE;
          end
        end else begin
          state_next = INFLIGHT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Address is latched on entry to OFFER so it stays stable for the whole offer.
  always_comb begin
    ser_valid_next = (state_next == OFFER);
    if ((state != OFFER) && (state_next == OFFER)) begin
      ser_addr_next = mem[rd_ptr_next];
    end else begin
      ser_addr_next = ser_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ser_valid  <= 1'b0;
      ser_addr   <= '0;
      push_ready <= 1'b1;
      overflow   <= 1'b0;
      abort_cnt  <= 8'd0;
    end else begin
      ser_valid  <= ser_valid_next;
      ser_addr   <= ser_addr_next;
      push_ready <= push_ready_next;
      overflow   <= overflow_next;
      abort_cnt  <= abort_cnt_next;
    end
  end

endmodule
